// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC control unit: FSM states, opcodes,
// datapath select codes and instruction field helpers.
package punc_control_pkg;

    // FSM state encoding
    localparam logic [2:0] STATE_INIT   = 3'd0;
    localparam logic [2:0] STATE_FETCH  = 3'd1;
    localparam logic [2:0] STATE_DECODE = 3'd2;
    localparam logic [2:0] STATE_EXEC   = 3'd3;
    localparam logic [2:0] STATE_EXEC2  = 3'd4;
    localparam logic [2:0] STATE_HALT   = 3'd5;

    // LC3 opcodes (ir[15:12])
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSVD = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // ALU operation select
    localparam logic [4:0] ALU_ADD     = 5'd0;
    localparam logic [4:0] ALU_ADDI    = 5'd1;
    localparam logic [4:0] ALU_AND     = 5'd2;
    localparam logic [4:0] ALU_ANDI    = 5'd3;
    localparam logic [4:0] ALU_NOT     = 5'd4;
    localparam logic [4:0] ALU_BR      = 5'd5;
    localparam logic [4:0] ALU_JMP_RET = 5'd6;
    localparam logic [4:0] ALU_JSR     = 5'd7;
    localparam logic [4:0] ALU_JSRR    = 5'd8;
    localparam logic [4:0] ALU_LD      = 5'd9;
    localparam logic [4:0] ALU_LDR     = 5'd10;
    localparam logic [4:0] ALU_LDI1    = 5'd11;
    localparam logic [4:0] ALU_LDI2    = 5'd12;
    localparam logic [4:0] ALU_LEA     = 5'd13;
    localparam logic [4:0] ALU_ST      = 5'd14;
    localparam logic [4:0] ALU_STR     = 5'd15;
    localparam logic [4:0] ALU_STI1    = 5'd16;

    // Memory and register-file mux selects
    localparam logic [1:0] MEM_R_CTRL      = 2'd1;
    localparam logic [1:0] MEM_R_ALU       = 2'd2;
    localparam logic [1:0] MEM_W_ADDR_ALU  = 2'd1;
    localparam logic [1:0] MEM_W_ADDR_SELF = 2'd2;
    localparam logic [1:0] MEM_W_DATA_R0   = 2'd1;
    localparam logic [1:0] RF_W_ALU        = 2'd1;
    localparam logic [1:0] RF_W_MEM        = 2'd2;
    localparam logic [1:0] RF_W_PC         = 2'd3;

    localparam logic [2:0] RF_R7 = 3'd7;

    // Instruction class after decode
    typedef enum logic [3:0] {
        OPC_NOP, OPC_ADD, OPC_AND, OPC_NOT, OPC_BR, OPC_JMP, OPC_JSR,
        OPC_LD, OPC_LDI, OPC_LDR, OPC_LEA, OPC_ST, OPC_STI, OPC_STR,
        OPC_TRAP, OPC_RSVD
    } op_class_e;

    // Instruction field helpers
    function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [2:0] ir_dr(input logic [15:0] ir);
        return ir[11:9];
    endfunction

    function automatic logic [2:0] ir_sr1(input logic [15:0] ir);
        return ir[8:6];
    endfunction

    function automatic logic [2:0] ir_sr2(input logic [15:0] ir);
        return ir[2:0];
    endfunction

endpackage

// File: rtl/punc_control_if.sv
// Control bus between the PUnC control unit (master) and datapath (slave).
interface punc_control_if;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        pc_inc;
    logic        pc_clr;
    logic        pc_w_en;
    logic        ir_w_en;
    logic [15:0] mem_r_addr_ctrl;
    logic [1:0]  mem_r_s;
    logic [1:0]  mem_w_addr_s;
    logic [1:0]  mem_w_data_s;
    logic        mem_w_en;
    logic [4:0]  alu_s;
    logic        rf_w_en;
    logic [1:0]  rf_w_s;
    logic [2:0]  rf_w_addr;
    logic [2:0]  rf_r0_addr;
    logic [2:0]  rf_r1_addr;
    logic [15:0] rf_w_data_ctrl;
    logic        status_w_en;
    logic        halted;

    modport master (
        input  pc, ir,
        output pc_inc, pc_clr, pc_w_en, ir_w_en, mem_r_addr_ctrl, mem_r_s,
               mem_w_addr_s, mem_w_data_s, mem_w_en, alu_s, rf_w_en, rf_w_s,
               rf_w_addr, rf_r0_addr, rf_r1_addr, rf_w_data_ctrl, status_w_en,
               halted
    );

    modport slave (
        output pc, ir,
        input  pc_inc, pc_clr, pc_w_en, ir_w_en, mem_r_addr_ctrl, mem_r_s,
               mem_w_addr_s, mem_w_data_s, mem_w_en, alu_s, rf_w_en, rf_w_s,
               rf_w_addr, rf_r0_addr, rf_r1_addr, rf_w_data_ctrl, status_w_en,
               halted
    );
endinterface

// File: rtl/punc_op_decode.sv
// Combinational instruction decode: opcode class and register fields.
module punc_op_decode
    import punc_control_pkg::*;
(
    input  logic [15:0] ir_i,
    output op_class_e   op_class_o,
    output logic [2:0]  dr_o,
    output logic [2:0]  sr1_o,
    output logic [2:0]  sr2_o,
    output logic        imm_o,
    output logic        jsr_o
);

    // ir[4:3] carry immediate bits that the control unit never needs
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_i[4:3];

    assign dr_o  = ir_dr(ir_i);
    assign sr1_o = ir_sr1(ir_i);
    assign sr2_o = ir_sr2(ir_i);
    assign imm_o = ir_i[5];
    assign jsr_o = ir_i[11];

    // Map the 4-bit opcode onto an instruction class
    always_comb begin
        op_class_o = OPC_NOP;
        case (ir_opcode(ir_i))
            OP_BR:   op_class_o = OPC_BR;
            OP_ADD:  op_class_o = OPC_ADD;
            OP_LD:   op_class_o = OPC_LD;
            OP_ST:   op_class_o = OPC_ST;
            OP_JSR:  op_class_o = OPC_JSR;
            OP_AND:  op_class_o = OPC_AND;
            OP_LDR:  op_class_o = OPC_LDR;
            OP_STR:  op_class_o = OPC_STR;
            OP_RTI:  op_class_o = OPC_RSVD;
            OP_NOT:  op_class_o = OPC_NOT;
            OP_LDI:  op_class_o = OPC_LDI;
            OP_STI:  op_class_o = OPC_STI;
            OP_JMP:  op_class_o = OPC_JMP;
            OP_RSVD: op_class_o = OPC_RSVD;
            OP_LEA:  op_class_o = OPC_LEA;
            OP_TRAP: op_class_o = OPC_TRAP;
            default: op_class_o = OPC_NOP;
        endcase
    end

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control unit: FETCH -> DECODE -> EXEC [-> EXEC2] sequencer
// driving every datapath control from the current state and IR.
module punc_control
    import punc_control_pkg::*;
#(
    parameter bit HALT_ON_TRAP     = 1'b1,
    parameter bit HALT_ON_RESERVED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    punc_control_if.master ctl
);

    logic [2:0] state_q, state_d;

    op_class_e  op_class;
    logic [2:0] dr, sr1, sr2;
    logic       imm, jsr;
    logic       halt_op;

    logic        pc_inc, pc_clr, pc_w_en, ir_w_en;
    logic [15:0] mem_r_addr_ctrl;
    logic [1:0]  mem_r_s, mem_w_addr_s, mem_w_data_s;
    logic        mem_w_en;
    logic [4:0]  alu_s;
    logic        rf_w_en;
    logic [1:0]  rf_w_s;
    logic [2:0]  rf_w_addr, rf_r0_addr, rf_r1_addr;
    logic        status_w_en, halted;

    punc_op_decode u_decode (
        .ir_i       (ctl.ir),
        .op_class_o (op_class),
        .dr_o       (dr),
        .sr1_o      (sr1),
        .sr2_o      (sr2),
        .imm_o      (imm),
        .jsr_o      (jsr)
    );

    assign halt_op = ((op_class == OPC_TRAP) && HALT_ON_TRAP) ||
                     ((op_class == OPC_RSVD) && HALT_ON_RESERVED);

    // State register, asynchronously forced to INIT by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= STATE_INIT;
        else     state_q <= state_d;
    end

    // Next-state sequencing
    always_comb begin
        state_d = STATE_INIT;
        case (state_q)
            STATE_INIT:   state_d = STATE_FETCH;
            STATE_FETCH:  state_d = STATE_DECODE;
            STATE_DECODE: state_d = halt_op ? STATE_HALT : STATE_EXEC;
            STATE_EXEC:   state_d = (op_class == OPC_LDI) ? STATE_EXEC2 : STATE_FETCH;
            STATE_EXEC2:  state_d = STATE_FETCH;
            STATE_HALT:   state_d = STATE_HALT;
            default:      state_d = STATE_INIT;
        endcase
    end

    // Datapath controls from state and decoded instruction
    always_comb begin
        pc_inc          = 1'b0;
        pc_clr          = 1'b0;
        pc_w_en         = 1'b0;
        ir_w_en         = 1'b0;
        mem_r_addr_ctrl = '0;
        mem_r_s         = '0;
        mem_w_addr_s    = '0;
        mem_w_data_s    = '0;
        mem_w_en        = 1'b0;
        alu_s           = '0;
        rf_w_en         = 1'b0;
        rf_w_s          = '0;
        rf_w_addr       = '0;
        rf_r0_addr      = '0;
        rf_r1_addr      = '0;
        status_w_en     = 1'b0;
        halted          = 1'b0;
        case (state_q)
            STATE_INIT: pc_clr = 1'b1;
            STATE_FETCH: begin
                mem_r_s         = MEM_R_CTRL;
                mem_r_addr_ctrl = ctl.pc;
                ir_w_en         = 1'b1;
                pc_inc          = 1'b1;
            end
            STATE_EXEC: begin
                case (op_class)
                    OPC_ADD, OPC_AND: begin
                        if (op_class == OPC_ADD) alu_s = imm ? ALU_ADDI : ALU_ADD;
                        else                     alu_s = imm ? ALU_ANDI : ALU_AND;
                        rf_r0_addr  = sr1;
                        rf_r1_addr  = sr2;
                        rf_w_s      = RF_W_ALU;
                        rf_w_addr   = dr;
                        rf_w_en     = 1'b1;
                        status_w_en = 1'b1;
                    end
                    OPC_NOT: begin
                        alu_s       = ALU_NOT;
                        rf_r0_addr  = sr1;
                        rf_w_s      = RF_W_ALU;
                        rf_w_addr   = dr;
                        rf_w_en     = 1'b1;
                        status_w_en = 1'b1;
                    end
                    OPC_BR: begin
                        alu_s   = ALU_BR;
                        pc_w_en = 1'b1;
                    end
                    OPC_JMP: begin
                        alu_s      = ALU_JMP_RET;
                        rf_r0_addr = sr1;
                        pc_w_en    = 1'b1;
                    end
                    // R7 write and PC load share the edge; JSRR R7 reads the old R7
                    OPC_JSR: begin
                        alu_s      = jsr ? ALU_JSR : ALU_JSRR;
                        rf_r0_addr = sr1;
                        pc_w_en    = 1'b1;
                        rf_w_s     = RF_W_PC;
                        rf_w_addr  = RF_R7;
                        rf_w_en    = 1'b1;
                    end
                    OPC_LD, OPC_LDR: begin
                        alu_s       = (op_class == OPC_LD) ? ALU_LD : ALU_LDR;
                        rf_r0_addr  = (op_class == OPC_LDR) ? sr1 : 3'd0;
                        mem_r_s     = MEM_R_ALU;
                        rf_w_s      = RF_W_MEM;
                        rf_w_addr   = dr;
                        rf_w_en     = 1'b1;
                        status_w_en = 1'b1;
                    end
                    OPC_LEA: begin
                        alu_s       = ALU_LEA;
                        rf_w_s      = RF_W_ALU;
                        rf_w_addr   = dr;
                        rf_w_en     = 1'b1;
                        status_w_en = 1'b1;
                    end
                    // First LDI cycle parks the pointer in DR; flags wait for EXEC2
                    OPC_LDI: begin
                        alu_s     = ALU_LDI1;
                        mem_r_s   = MEM_R_ALU;
                        rf_w_s    = RF_W_MEM;
                        rf_w_addr = dr;
                        rf_w_en   = 1'b1;
                    end
                    OPC_ST: begin
                        alu_s        = ALU_ST;
                        rf_r0_addr   = dr;
                        mem_w_addr_s = MEM_W_ADDR_ALU;
                        mem_w_data_s = MEM_W_DATA_R0;
                        mem_w_en     = 1'b1;
                    end
                    OPC_STR: begin
                        alu_s        = ALU_STR;
                        rf_r0_addr   = dr;
                        rf_r1_addr   = sr1;
                        mem_w_addr_s = MEM_W_ADDR_ALU;
                        mem_w_data_s = MEM_W_DATA_R0;
                        mem_w_en     = 1'b1;
                    end
                    // Pointer is read and used as the write address in one cycle
                    OPC_STI: begin
                        alu_s        = ALU_STI1;
                        mem_r_s      = MEM_R_ALU;
                        mem_w_addr_s = MEM_W_ADDR_SELF;
                        rf_r0_addr   = dr;
                        mem_w_data_s = MEM_W_DATA_R0;
                        mem_w_en     = 1'b1;
                    end
                    default: ;
                endcase
            end
            STATE_EXEC2: begin
                alu_s       = ALU_LDI2;
                rf_r0_addr  = dr;
                mem_r_s     = MEM_R_ALU;
                rf_w_s      = RF_W_MEM;
                rf_w_addr   = dr;
                rf_w_en     = 1'b1;
                status_w_en = 1'b1;
            end
            STATE_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign ctl.pc_inc          = pc_inc;
    assign ctl.pc_clr          = pc_clr;
    assign ctl.pc_w_en         = pc_w_en;
    assign ctl.ir_w_en         = ir_w_en;
    assign ctl.mem_r_addr_ctrl = mem_r_addr_ctrl;
    assign ctl.mem_r_s         = mem_r_s;
    assign ctl.mem_w_addr_s    = mem_w_addr_s;
    assign ctl.mem_w_data_s    = mem_w_data_s;
    assign ctl.mem_w_en        = mem_w_en;
    assign ctl.alu_s           = alu_s;
    assign ctl.rf_w_en         = rf_w_en;
    assign ctl.rf_w_s          = rf_w_s;
    assign ctl.rf_w_addr       = rf_w_addr;
    assign ctl.rf_r0_addr      = rf_r0_addr;
    assign ctl.rf_r1_addr      = rf_r1_addr;
    assign ctl.rf_w_data_ctrl  = '0;
    assign ctl.status_w_en     = status_w_en;
    assign ctl.halted          = halted;

endmodule
